// File: rtl/sdram_host_adapter.sv
// sdram_host_adapter: host-side front end for sdram_controller.
// Host requests are queued in a small FIFO and issued one at a time on the
// controller's level-sensitive enable/busy interface. Read data returns in
// request order on a valid/ready response port.
`timescale 1ns/1ps

module sdram_host_adapter #(
  parameter int HADDR_WIDTH = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]            req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   idle,
  output logic                   timeout_err,
  output logic [HADDR_WIDTH-1:0] sd_wr_addr,
  output logic [15:0]            sd_wr_data,
  output logic                   sd_wr_enable,
  output logic [HADDR_WIDTH-1:0] sd_rd_addr,
  output logic                   sd_rd_enable,
  input  logic [15:0]            sd_rd_data,
  input  logic                   sd_rd_ready,
  input  logic                   sd_busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [9:0]       TMO_LAST   = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_WR,
    S_WAIT_RD,
    S_RSP
  } state_t;

  state_t state;

  logic                   fifo_we    [FIFO_DEPTH];
  logic [HADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [15:0]            fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;

  logic                   fifo_empty;
  logic                   head_we;
  logic                   push;
  logic                   pop;

  logic                   op_we;
  logic [HADDR_WIDTH-1:0] op_addr;
  logic [15:0]            op_wdata;
  logic [9:0]             tmo_cnt;

  assign fifo_empty = (count == '0);
  assign req_ready  = (count != FULL_COUNT);
  assign head_we    = fifo_we[rd_ptr];
  assign push       = req_valid && req_ready;

  // A read may not start while an earlier read response is still unaccepted,
  // and nothing starts while the controller still reports busy from the last op.
  assign pop  = (state == S_IDLE) && !fifo_empty && (head_we || !rsp_valid) && !sd_busy;
  assign idle = fifo_empty && (state == S_IDLE);

  // The controller latches address/data while an enable is high, so both are
  // driven straight from the active-op register and stay fixed for the op.
  assign sd_wr_addr = op_addr;
  assign sd_rd_addr = op_addr;
  assign sd_wr_data = op_wdata;

  // Request storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]    <= req_we;
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_wdata[wr_ptr] <= req_wdata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Op sequencer: pop one request, hold its enable until busy is seen, then
  // wait for completion and (for reads) present the response to the host.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sd_wr_enable <= 1'b0;
      sd_rd_enable <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      timeout_err  <= 1'b0;
      op_we        <= 1'b0;
      op_addr      <= '0;
      op_wdata     <= '0;
      tmo_cnt      <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            op_we        <= head_we;
            op_addr      <= fifo_addr[rd_ptr];
            op_wdata     <= fifo_wdata[rd_ptr];
            sd_wr_enable <= head_we;
            sd_rd_enable <= !head_we;
            tmo_cnt      <= '0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sd_busy) begin
            sd_wr_enable <= 1'b0;
            sd_rd_enable <= 1'b0;
            if (op_we) begin
              state <= S_WAIT_WR;
            end else if (sd_rd_ready) begin
              rsp_rdata <= sd_rd_data;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= S_RSP;
            end else begin
              state <= S_WAIT_RD;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            sd_wr_enable <= 1'b0;
            sd_rd_enable <= 1'b0;
            timeout_err  <= 1'b1;
            if (op_we) begin
              state <= S_IDLE;
            end else begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RSP;
            end
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        S_WAIT_WR: begin
          if (!sd_busy) state <= S_IDLE;
        end
        S_WAIT_RD: begin
          if (sd_rd_ready) begin
            rsp_rdata <= sd_rd_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end
        end
        S_RSP: begin
          // Leave on the handshake, or early when a write is queued so it can
          // run underneath the pending response (rsp_valid stays held).
          if (!rsp_valid || rsp_ready || (!fifo_empty && head_we)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
